// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide engine:
// FSM state encoding, operation codes and the default word width.
package cpu_pkg;

  localparam int MD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iteration datapath: shift-add multiply or restoring shift-subtract
// divide on operand magnitudes, one step per step_i cycle.
module md_iter_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_mag_i,
  input  logic [WIDTH-1:0] b_mag_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic             op_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  // hi holds the partial product (mul) or partial remainder (div);
  // lo holds the multiplier being shifted out or the dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (op_q == OP_MUL) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
      op_q <= OP_MUL;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_mag_i;
      b_q  <= b_mag_i;
      op_q <= op_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide for the EX stage: IDLE/RUN/FIX sequencer,
// iteration counter and sign correction around the unsigned md_iter_core.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q, neg_lo_q, neg_hi_q, dbz_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             busy_q, done_q, dbz_flag_q;

  logic             accept, step;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign accept   = (state_q == IDLE) && start && !flush;
  assign step     = (state_q == RUN) && !flush;
  assign a_mag    = neg_if(a[WIDTH-1], a);
  assign b_mag    = neg_if(b[WIDTH-1], b);
  assign prod     = {core_hi, core_lo};
  assign prod_fix = neg_lo_q ? (~prod + 1'b1) : prod;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .step_i  (step),
    .op_i    (op),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      dbz_q       <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_flag_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op;
            neg_lo_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi_q   <= a[WIDTH-1];
            dbz_q      <= (op == OP_DIV) && (b == '0);
            dbz_flag_q <= 1'b0;
            cnt_q      <= CW'(WIDTH);
            busy_q     <= 1'b1;
            state_q    <= ((op == OP_DIV) && (b == '0)) ? FIX : RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q <= 1'b1;
            // Divide-by-zero skips RUN, so the core still holds |a| in lo.
            if (dbz_q) begin
              result_q    <= '1;
              result_hi_q <= neg_if(neg_hi_q, core_lo);
              dbz_flag_q  <= 1'b1;
            end else if (op_q == OP_MUL) begin
              result_q    <= prod_fix[WIDTH-1:0];
              result_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            end else begin
              result_q    <= neg_if(neg_lo_q, core_lo);
              result_hi_q <= neg_if(neg_hi_q, core_hi);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_flag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {result_hi,result} words are
// queued at each accepted start and popped when done pulses.
module tb_mul_div_unit;

  logic        clk, reset, start, op, flush;
  logic [15:0] a, b, result, result_hi;
  logic        busy, done, div_by_zero;

  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  mul_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .flush       (flush),
    .a           (a),
    .b           (b),
    .result      (result),
    .result_hi   (result_hi),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, q, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == 1'b0) return 32'(sx * sy);
    if (y == 16'h0000) return {x, 16'hFFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[15:0], q[15:0]};
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; start is high across exactly one rising edge.
  task automatic drive_start(input logic o, input logic [15:0] x, input logic [15:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts rising edges after the start edge until done is seen.
  task automatic wait_done(input int budget, output int lat, output int busy_n, output logic got);
    lat = 0; busy_n = 0; got = 1'b0;
    while (!got && lat < budget) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({result_hi, result, busy, done, div_by_zero} !== 35'd0)
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b dbz=%b, want all 0",
               result_hi, result, busy, done, div_by_zero);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int lat, bn; logic got; logic [31:0] e;
    drive_start(1'b0, 16'h0007, 16'hFFFD);
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got) $display("FAIL mul_basic_timeout: no done within 40 cycles");
    else pass_cnt++;
    tot_cnt++;
    if ({result_hi, result} !== e) $display("FAIL mul_basic: got %h_%h want %h", result_hi, result, e);
    else pass_cnt++;
    tot_cnt++;
    if (lat !== 17) $display("FAIL mul_latency: got %0d want 17", lat);
    else pass_cnt++;
    tot_cnt++;
    if (bn !== 17) $display("FAIL mul_busy_cycles: got %0d want 17", bn);
    else pass_cnt++;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL mul_busy_at_done: got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_mul_ignore_start();
    int lat, bn, extra; logic got; logic [31:0] e;
    drive_start(1'b0, 16'h7FFF, 16'h7FFF);
    repeat (4) @(negedge clk);
    op = 1'b1; a = 16'h0001; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got || {result_hi, result} !== e)
      $display("FAIL mul_max: got=%b %h_%h want %h", got, result_hi, result, e);
    else pass_cnt++;
    tot_cnt++;
    if (lat + 5 !== 17) $display("FAIL mul_max_latency: got %0d want 17", lat + 5);
    else pass_cnt++;
    extra = 0;
    @(negedge clk);
    repeat (25) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    tot_cnt++;
    if (extra !== 0) $display("FAIL ignored_start: got %0d busy/done cycles want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, bn; logic got; logic [31:0] e;
    logic [15:0] da[2] = '{16'hFFF9, 16'h8000};
    logic [15:0] db[2] = '{16'h0002, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      drive_start(1'b1, da[i], db[i]);
      wait_done(40, lat, bn, got);
      e = exp_q.pop_front();
      tot_cnt++;
      if (!got || {result_hi, result} !== e || lat !== 17)
        $display("FAIL div_%0d: got=%b %h_%h lat=%0d want %h lat=17", i, got, result_hi, result, lat, e);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bn; logic got; logic [31:0] e;
    drive_start(1'b1, 16'h0005, 16'h0000);
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got || lat !== 1) $display("FAIL dbz_latency: got=%b lat=%0d want 1", got, lat);
    else pass_cnt++;
    tot_cnt++;
    if ({result_hi, result} !== e) $display("FAIL dbz_result: got %h_%h want %h", result_hi, result, e);
    else pass_cnt++;
    tot_cnt++;
    if (div_by_zero !== 1'b1) $display("FAIL dbz_flag: got %b want 1", div_by_zero);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (div_by_zero !== 1'b1) $display("FAIL dbz_sticky: got %b want 1", div_by_zero);
    else pass_cnt++;
    drive_start(1'b0, 16'h0002, 16'h0003);
    tot_cnt++;
    if (div_by_zero !== 1'b0) $display("FAIL dbz_clear: got %b want 0", div_by_zero);
    else pass_cnt++;
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got || {result_hi, result} !== e) $display("FAIL mul_after_dbz: got %h_%h want %h", result_hi, result, e);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] prev; int extra;
    prev = {result_hi, result};
    drive_start(1'b0, 16'h1234, 16'h0056);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tot_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_busy: got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    tot_cnt++;
    if ({result_hi, result} !== prev) $display("FAIL flush_hold: got %h_%h want %h", result_hi, result, prev);
    else pass_cnt++;
    extra = 0;
    repeat (25) begin
      if (done) extra++;
      @(negedge clk);
    end
    tot_cnt++;
    if (extra !== 0) $display("FAIL flush_no_done: got %0d dones want 0", extra);
    else pass_cnt++;
    op = 1'b0; a = 16'h0003; b = 16'h0004; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_wins_start: got busy=%b want 0", busy);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive_start(1'b0, 16'h0100, 16'h0200);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tot_cnt++;
    if ({result_hi, result, busy, done, div_by_zero} !== 35'd0)
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b dbz=%b want all 0",
               result_hi, result, busy, done, div_by_zero);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    tot_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_quiet: got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic got; logic [31:0] e;
    drive_start(1'b0, 16'hFF00, 16'h0123);
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got || {result_hi, result} !== e) $display("FAIL b2b_first: got %h_%h want %h", result_hi, result, e);
    else pass_cnt++;
    drive_start(1'b1, 16'h7FFF, 16'hFFF0);
    wait_done(40, lat, bn, got);
    e = exp_q.pop_front();
    tot_cnt++;
    if (!got || {result_hi, result} !== e || lat !== 17)
      $display("FAIL b2b_second: got=%b %h_%h lat=%0d want %h lat=17", got, result_hi, result, lat, e);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bn, want_lat; logic got; logic [31:0] e; logic o; logic [15:0] x, y;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(1, 0));
      x = 16'($urandom_range(16'hFFFF, 0));
      y = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom_range(16'hFFFF, 0));
      want_lat = (o && y == 16'h0000) ? 1 : 17;
      drive_start(o, x, y);
      wait_done(40, lat, bn, got);
      e = exp_q.pop_front();
      tot_cnt++;
      if (!got || {result_hi, result} !== e || lat !== want_lat)
        $display("FAIL rand_%0d op=%b a=%h b=%h: got=%b %h_%h lat=%0d want %h lat=%0d",
                 i, o, x, y, got, result_hi, result, lat, e, want_lat);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; flush = 1'b0; a = '0; b = '0;
    test_reset();
    test_mul_basic();
    test_mul_ignore_start();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    tot_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
